// File: rtl/fetch_pkg.sv
// Shared fetch/decode definitions: FSM state encoding, next-pc select codes
// and the default opcode constants used by the fetch and decode stages.
package fetch_pkg;

    // Fetch FSM states. ISSUE covers the one-cycle instruction memory latency.
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ISSUE   = 3'd1,
        ST_LATCH   = 3'd2,
        ST_PRESENT = 3'd3,
        ST_HALTED  = 3'd4
    } fetch_state_e;

    // Next-pc source selection.
    typedef enum logic [1:0] {
        PC_HOLD   = 2'd0,
        PC_INC    = 2'd1,
        PC_JUMP   = 2'd2,
        PC_BRANCH = 2'd3
    } pc_sel_e;

    localparam logic [3:0] DEF_HALT_OP = 4'hF;
    localparam logic [3:0] DEF_JMP_OP  = 4'hE;

    // Opcode field of an 8-bit instruction word.
    function automatic logic [3:0] ir_opcode(input logic [7:0] ir);
        return ir[7:4];
    endfunction

    // Operand field of an 8-bit instruction word.
    function automatic logic [3:0] ir_operand(input logic [7:0] ir);
        return ir[3:0];
    endfunction

endpackage

// File: rtl/pc_next.sv
// Combinational next-pc selection: hold, +1 with 4-bit wrap, absolute jump
// to the instruction operand, or downstream branch redirect.
module pc_next
    import fetch_pkg::*;
#(
    parameter logic [3:0] HALT_OP = DEF_HALT_OP,
    parameter logic [3:0] JMP_OP  = DEF_JMP_OP
) (
    input  logic [3:0] pc_cur,
    input  logic       accept,
    input  logic [3:0] opcode,
    input  logic [3:0] operand,
    input  logic       branch_taken,
    input  logic [3:0] branch_target,
    output logic [3:0] pc_nxt
);

    pc_sel_e sel;

    // Choose the pc source; only an accept moves pc, a jump beats a branch
    // and a halt keeps pc where it is.
    always_comb begin
        sel = PC_HOLD;
        if (accept) begin
            if (opcode == HALT_OP) begin
                sel = PC_HOLD;
            end else if (opcode == JMP_OP) begin
                sel = PC_JUMP;
            end else if (branch_taken) begin
                sel = PC_BRANCH;
            end else begin
                sel = PC_INC;
            end
        end
    end

    // Mux the selected source; the 4-bit add wraps 15 to 0 naturally.
    always_comb begin
        pc_nxt = pc_cur;
        case (sel)
            PC_HOLD:   pc_nxt = pc_cur;
            PC_INC:    pc_nxt = pc_cur + 4'd1;
            PC_JUMP:   pc_nxt = operand;
            PC_BRANCH: pc_nxt = branch_target;
            default:   pc_nxt = pc_cur;
        endcase
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: drives pc to instruction memory, waits one cycle of
// memory latency, latches the returned word and presents it to decode.
//
// Handshake: ir_valid is high only in PRESENT and the held instruction is
// stable while ir_valid=1 and ir_ready=0; a transfer (accept) happens on the
// rising edge where ir_valid=1 and ir_ready=1. branch_taken/branch_target are
// only looked at on that accept cycle. ir_valid never depends on ir_ready.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [3:0] HALT_OP = DEF_HALT_OP,
    parameter logic [3:0] JMP_OP  = DEF_JMP_OP
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       run,
    input  logic [7:0] ins_data,
    output logic [3:0] pc,
    output logic       ir_valid,
    input  logic       ir_ready,
    output logic [3:0] opcode,
    output logic [3:0] operand,
    input  logic       branch_taken,
    input  logic [3:0] branch_target,
    output logic       halted,
    output logic [2:0] state_dbg
);

    fetch_state_e state_q, state_d;
    logic [3:0]   pc_q, pc_d;
    logic [7:0]   ir_q, ir_d;
    logic         accept;

    assign accept = (state_q == ST_PRESENT) && ir_ready;

    // Next-pc selection lives in its own combinational block.
    pc_next #(
        .HALT_OP (HALT_OP),
        .JMP_OP  (JMP_OP)
    ) u_pc_next (
        .pc_cur        (pc_q),
        .accept        (accept),
        .opcode        (ir_opcode(ir_q)),
        .operand       (ir_operand(ir_q)),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .pc_nxt        (pc_d)
    );

    // Next-state and instruction register load.
    always_comb begin
        state_d = state_q;
        ir_d    = ir_q;
        case (state_q)
            ST_IDLE: begin
                if (run) begin
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                // Memory is reading pc this cycle; data arrives in LATCH.
                state_d = ST_LATCH;
            end
            ST_LATCH: begin
                ir_d    = ins_data;
                state_d = ST_PRESENT;
            end
            ST_PRESENT: begin
                // run is only consulted once the held instruction is accepted.
                if (accept) begin
                    if (ir_opcode(ir_q) == HALT_OP) begin
                        state_d = ST_HALTED;
                    end else if (run) begin
                        state_d = ST_ISSUE;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_HALTED: begin
                state_d = ST_HALTED;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, pc and instruction registers with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            pc_q    <= 4'd0;
            ir_q    <= 8'h00;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
        end
    end

    assign pc        = pc_q;
    assign ir_valid  = (state_q == ST_PRESENT);
    assign opcode    = ir_opcode(ir_q);
    assign operand   = ir_operand(ir_q);
    assign halted    = (state_q == ST_HALTED);
    assign state_dbg = state_q;

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 The block SHALL have parameter HALT_OP, default 4'hF, meaning the opcode (ir[7:4]) that stops fetching.
REQ-002 The block SHALL have parameter JMP_OP, default 4'hE, meaning the opcode whose operand (ir[3:0]) is an absolute jump target.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port run, input, 1 bit: level enable; fetching proceeds while high.
REQ-006 The block SHALL have port ins_data, input, 8 bits: instruction word from instruction memory, valid one clk after pc changes.
REQ-007 The block SHALL have port pc, output, 4 bits: program counter driven to instruction memory.
REQ-008 The block SHALL have port ir_valid, output, 1 bit: held instruction is valid for downstream decode.
REQ-009 The block SHALL have port ir_ready, input, 1 bit: downstream accepts the held instruction this cycle.
REQ-010 The block SHALL have port opcode, output, 4 bits: ir[7:4] of the held instruction.
REQ-011 The block SHALL have port operand, output, 4 bits: ir[3:0] of the held instruction.
REQ-012 The block SHALL have port branch_taken, input, 1 bit: downstream redirect request, sampled only on the accept cycle.
REQ-013 The block SHALL have port branch_target, input, 4 bits: redirect address used when branch_taken is sampled high.
REQ-014 The block SHALL have port halted, output, 1 bit: high while in HALTED.

Function
REQ-015 The FSM SHALL have states IDLE, ISSUE, LATCH, PRESENT, HALTED.
REQ-016 From IDLE the FSM SHALL go to ISSUE on a cycle with run=1, otherwise stay in IDLE; pc SHALL be unchanged.
REQ-017 ISSUE SHALL last exactly one cycle (memory latency), then go to LATCH.
REQ-018 In LATCH the block SHALL load ir <= ins_data and go to PRESENT.
REQ-019 In PRESENT ir_valid SHALL be 1, and ir, opcode and operand SHALL be stable until the accept cycle (ir_valid & ir_ready).
REQ-020 On accept with opcode==HALT_OP the block SHALL go to HALTED with pc unchanged.
REQ-021 On accept with opcode==JMP_OP the block SHALL set pc <= operand, ignoring branch_taken.
REQ-022 On any other accept with branch_taken=1 the block SHALL set pc <= branch_target.
REQ-023 On any other accept with branch_taken=0 the block SHALL set pc <= pc+1, modulo 16 (15 wraps to 0).
REQ-024 After a non-halt accept the FSM SHALL go to ISSUE if run=1, else to IDLE.
REQ-025 Deasserting run in ISSUE, LATCH or PRESENT SHALL NOT abort the in-flight instruction; it completes its handshake first.
REQ-026 ir_valid SHALL be 0 in every state except PRESENT.
REQ-027 Best-case throughput SHALL be one instruction per 3 clk (ISSUE, LATCH, PRESENT with ir_ready=1).
REQ-028 HALTED SHALL be left only by reset; run, ir_ready and branch inputs SHALL be ignored there.

Reset
REQ-029 While rst_n=0 the block SHALL immediately drive state=IDLE, pc=0, ir=8'h00 (opcode=0, operand=0), ir_valid=0 and halted=0, independent of clk.
REQ-030 Reset asserted mid-operation SHALL discard any held instruction with no handshake completion.
REQ-031 After rst_n rises the block SHALL stay in IDLE until run=1 is sampled.

Structure
REQ-032 State encoding and default opcode constants (HALT_OP, JMP_OP) SHALL live in shared package fetch_pkg for reuse by the decode stage.
REQ-033 Next-pc selection (hold / +1 wrap / jump / branch) SHALL be a sub-module pc_next with purely combinational logic; state, pc and ir registers stay in fetch_unit.

Verification
REQ-034 Reset, run=1, memory [0]=8'h12,[1]=8'h34, ir_ready=1 -> pc 0,1,2 at 3-cycle spacing; opcode/operand 1/2 then 3/4; ir_valid high one cycle each.
REQ-035 At pc=15 with a plain instruction accepted and branch_taken=0 -> next pc=0.
REQ-036 ir_ready held 0 for 5 cycles in PRESENT -> ir_valid and ir stable throughout; pc advances only after ir_ready=1.
REQ-037 [3]=8'hE9 accepted with branch_taken=1, branch_target=4 -> pc=9 (jump wins); [5] plain with branch_taken=1, target=2 -> pc=2.
REQ-038 [2]=8'hF0 accepted -> halted=1, pc=2, no further ISSUE while run, ir_ready and branch_taken toggle; rst_n pulse -> halted=0, pc=0.
REQ-039 rst_n asserted between clk edges in PRESENT -> ir_valid=0 and pc=0 immediately; run dropped in LATCH -> instruction is still presented and accepted, then IDLE.
